// File: rtl/cpu_ctrl_fsm_if.sv
// rtl/cpu_ctrl_fsm_if.sv - control-unit handshake and datapath-control bundle
interface cpu_ctrl_fsm_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 run_i;
    logic [31:0]          instr_i;
    logic                 imem_req_o;
    logic                 imem_ack_i;
    logic                 ir_load_o;
    logic                 rf_re_o;
    logic [3:0]           alu_op_o;
    logic                 div_start_o;
    logic                 div_done_i;
    logic                 cmp_eq_i;
    logic                 cmp_gt_i;
    logic                 dmem_re_o;
    logic                 dmem_we_o;
    logic                 dmem_ack_i;
    logic                 rf_we_o;
    logic [1:0]           rf_wsel_o;
    logic                 pc_en_o;
    logic                 pc_sel_o;
    logic                 illegal_o;
    logic                 div_err_o;
    logic [CNT_WIDTH-1:0] instret_o;
    logic [2:0]           state_o;

    modport master (
        input  run_i, instr_i, imem_ack_i, div_done_i, cmp_eq_i, cmp_gt_i, dmem_ack_i,
        output imem_req_o, ir_load_o, rf_re_o, alu_op_o, div_start_o, dmem_re_o,
               dmem_we_o, rf_we_o, rf_wsel_o, pc_en_o, pc_sel_o, illegal_o,
               div_err_o, instret_o, state_o
    );

    modport slave (
        output run_i, instr_i, imem_ack_i, div_done_i, cmp_eq_i, cmp_gt_i, dmem_ack_i,
        input  imem_req_o, ir_load_o, rf_re_o, alu_op_o, div_start_o, dmem_re_o,
               dmem_we_o, rf_we_o, rf_wsel_o, pc_en_o, pc_sel_o, illegal_o,
               div_err_o, instret_o, state_o
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multicycle fetch/decode/execute/memory/writeback control unit
module cpu_ctrl_fsm #(
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    cpu_ctrl_fsm_if.master  bus
);
    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_DIV_WAIT = 3'd3,
        S_MEM      = 3'd4,
        S_WB       = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD = 4'h0, OP_LW  = 4'h1, OP_SW  = 4'h2, OP_SUB = 4'h3;
    localparam logic [3:0] OP_MUL = 4'h4, OP_DIV = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8, OP_BEQ = 4'h9, OP_BGT = 4'hA, OP_BGE = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC, OP_LI  = 4'hD;

    localparam int             DCW      = $clog2(DIV_TIMEOUT) + 1;
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV_TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [3:0]           opcode_q;
    logic [DCW-1:0]       div_cnt_q;
    logic [CNT_WIDTH-1:0] instret_q;
    logic                 div_err_q;

    logic       imem_req, ir_load, rf_re, div_start, dmem_re, dmem_we;
    logic       rf_we, pc_en, pc_sel, illegal, div_timeout, retire;
    logic [3:0] alu_op;
    logic [1:0] rf_wsel;

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        ir_load     = 1'b0;
        rf_re       = 1'b0;
        alu_op      = 4'h0;
        div_start   = 1'b0;
        dmem_re     = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        rf_wsel     = 2'd0;
        pc_en       = 1'b0;
        pc_sel      = 1'b0;
        illegal     = 1'b0;
        div_timeout = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = bus.run_i;
                if (bus.run_i && bus.imem_ack_i) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                rf_re = 1'b1;
                if (opcode_q >= 4'hE) begin
                    illegal = 1'b1;
                    pc_en   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opcode_q)
                    OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: begin
                        alu_op  = opcode_q;
                        state_d = S_WB;
                    end
                    OP_DIV: begin
                        alu_op    = OP_DIV;
                        div_start = 1'b1;
                        state_d   = S_DIV_WAIT;
                    end
                    OP_LW, OP_SW: begin
                        alu_op  = OP_ADD;
                        state_d = S_MEM;
                    end
                    OP_BEQ, OP_BGT, OP_BGE: begin
                        alu_op  = OP_SUB;
                        pc_en   = 1'b1;
                        pc_sel  = (opcode_q == OP_BEQ) ? bus.cmp_eq_i :
                                  (opcode_q == OP_BGT) ? bus.cmp_gt_i :
                                                         (bus.cmp_gt_i | bus.cmp_eq_i);
                        state_d = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_en   = 1'b1;
                        pc_sel  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_LI:   state_d = S_WB;
                    default: state_d = S_FETCH;
                endcase
            end
            S_DIV_WAIT: begin
                alu_op = OP_DIV;
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (bus.div_done_i) begin
                    state_d = S_WB;
                end else if (div_cnt_q == DIV_LAST) begin
                    div_timeout = 1'b1;
                    pc_en       = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_MEM: begin
                if (opcode_q == OP_LW) begin
                    dmem_re = 1'b1;
                    if (bus.dmem_ack_i) state_d = S_WB;
                end else begin
                    dmem_we = 1'b1;
                    if (bus.dmem_ack_i) begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_wsel = (opcode_q == OP_LW) ? 2'd1 : (opcode_q == OP_LI) ? 2'd2 : 2'd0;
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign retire = pc_en & ~illegal & ~div_timeout;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            opcode_q  <= 4'h0;
            div_cnt_q <= '0;
            instret_q <= '0;
            div_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ir_load) opcode_q <= bus.instr_i[3:0];
            if (div_start)                  div_cnt_q <= '0;
            else if (state_q == S_DIV_WAIT) div_cnt_q <= div_cnt_q + 1'b1;
            if (retire)      instret_q <= instret_q + 1'b1;
            if (div_timeout) div_err_q <= 1'b1;
        end
    end

    // The fetch handshake is the only path not already zeroed by the async state reset.
    assign bus.imem_req_o  = imem_req & ~rst_i;
    assign bus.ir_load_o   = ir_load & ~rst_i;
    assign bus.rf_re_o     = rf_re;
    assign bus.alu_op_o    = alu_op;
    assign bus.div_start_o = div_start;
    assign bus.dmem_re_o   = dmem_re;
    assign bus.dmem_we_o   = dmem_we;
    assign bus.rf_we_o     = rf_we;
    assign bus.rf_wsel_o   = rf_wsel;
    assign bus.pc_en_o     = pc_en;
    assign bus.pc_sel_o    = pc_sel;
    assign bus.illegal_o   = illegal;
    assign bus.div_err_o   = div_err_q;
    assign bus.instret_o   = instret_q;
    assign bus.state_o     = state_q;
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - directed self-checking bench for cpu_ctrl_fsm
module tb_cpu_ctrl_fsm;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n;
    int   pulses;
    logic last_pc_en;

    cpu_ctrl_fsm_if #(.CNT_WIDTH(32)) bus ();

    cpu_ctrl_fsm #(.DIV_TIMEOUT(64), .CNT_WIDTH(32)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    function automatic logic [31:0] all_outs();
        return {15'd0, bus.imem_req_o, bus.ir_load_o, bus.rf_re_o, bus.alu_op_o,
                bus.div_start_o, bus.dmem_re_o, bus.dmem_we_o, bus.rf_we_o,
                bus.rf_wsel_o, bus.pc_en_o, bus.pc_sel_o, bus.illegal_o, bus.div_err_o};
    endfunction

    // Fetch one word with a zero-wait ack and land in DECODE.
    task automatic fetch(input logic [31:0] w);
        bus.instr_i    = w;
        bus.imem_ack_i = 1'b1;
        #1;
        chk("fetch_state", 32'(bus.state_o), 32'd0);
        chk("fetch_ir_load", 32'(bus.ir_load_o), 32'd1);
        tick();
        bus.imem_ack_i = 1'b0;
        #1;
        chk("decode_state", 32'(bus.state_o), 32'd1);
        chk("decode_rf_re", 32'(bus.rf_re_o), 32'd1);
    endtask

    task automatic branch(input logic [31:0] w, input logic eq, input logic gt,
                          input logic taken, input logic [31:0] ret);
        fetch(w);
        tick();
        bus.cmp_eq_i = eq;
        bus.cmp_gt_i = gt;
        #1;
        chk("br_state", 32'(bus.state_o), 32'd2);
        chk("br_alu_op", 32'(bus.alu_op_o), 32'd3);
        chk("br_pc_en", 32'(bus.pc_en_o), 32'd1);
        chk("br_pc_sel", 32'(bus.pc_sel_o), 32'(taken));
        chk("br_rf_we", 32'(bus.rf_we_o), 32'd0);
        tick();
        bus.cmp_eq_i = 1'b0;
        bus.cmp_gt_i = 1'b0;
        #1;
        chk("br_back_fetch", 32'(bus.state_o), 32'd0);
        chk("br_instret", bus.instret_o, ret);
    endtask

    initial begin
        bus.run_i = 1'b1; bus.instr_i = '0; bus.imem_ack_i = 1'b0; bus.div_done_i = 1'b0;
        bus.cmp_eq_i = 1'b0; bus.cmp_gt_i = 1'b0; bus.dmem_ack_i = 1'b0;
        #1;
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_outs", all_outs(), 32'd0);
        chk("rst_instret", bus.instret_o, 32'd0);
        tick();
        rst_i = 1'b0;
        #1;
        chk("post_rst_req", 32'(bus.imem_req_o), 32'd1);

        // ADD: 0,1,2,5
        fetch(32'h00004230);
        tick(); #1;
        chk("add_exec", 32'(bus.state_o), 32'd2);
        chk("add_alu_op", 32'(bus.alu_op_o), 32'd0);
        tick(); #1;
        chk("add_wb", 32'(bus.state_o), 32'd5);
        chk("add_rf_we", 32'(bus.rf_we_o), 32'd1);
        chk("add_wsel", 32'(bus.rf_wsel_o), 32'd0);
        chk("add_pc_en", 32'(bus.pc_en_o), 32'd1);
        tick(); #1;
        chk("add_fetch", 32'(bus.state_o), 32'd0);
        chk("add_instret", bus.instret_o, 32'd1);

        // LW, ack on 4th MEM cycle: 8 cycles total
        fetch(32'h00780801);
        tick(); #1;
        chk("lw_exec_alu", 32'(bus.alu_op_o), 32'd0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.dmem_ack_i = (i == 3);
            #1;
            chk("lw_mem_state", 32'(bus.state_o), 32'd4);
            chk("lw_dmem_re", 32'(bus.dmem_re_o), 32'd1);
            chk("lw_dmem_we", 32'(bus.dmem_we_o), 32'd0);
        end
        tick();
        bus.dmem_ack_i = 1'b0;
        #1;
        chk("lw_wb", 32'(bus.state_o), 32'd5);
        chk("lw_wsel", 32'(bus.rf_wsel_o), 32'd1);
        chk("lw_rf_we", 32'(bus.rf_we_o), 32'd1);
        tick(); #1;
        chk("lw_instret", bus.instret_o, 32'd2);

        // SW, zero-wait ack
        fetch(32'h0078E802);
        tick(); #1;
        tick();
        bus.dmem_ack_i = 1'b1;
        #1;
        chk("sw_mem", 32'(bus.state_o), 32'd4);
        chk("sw_we", 32'(bus.dmem_we_o), 32'd1);
        chk("sw_re", 32'(bus.dmem_re_o), 32'd0);
        chk("sw_pc_en", 32'(bus.pc_en_o), 32'd1);
        chk("sw_rf_we", 32'(bus.rf_we_o), 32'd0);
        tick();
        bus.dmem_ack_i = 1'b0;
        #1;
        chk("sw_fetch", 32'(bus.state_o), 32'd0);
        chk("sw_instret", bus.instret_o, 32'd3);

        branch(32'h00790809, 1'b1, 1'b0, 1'b1, 32'd4);  // BEQ taken
        branch(32'h00790809, 1'b0, 1'b1, 1'b0, 32'd5);  // BEQ not taken
        branch(32'h0079080B, 1'b1, 1'b0, 1'b1, 32'd6);  // BGE on equal
        branch(32'h0079080A, 1'b1, 1'b0, 1'b0, 32'd7);  // BGT not taken on equal

        // LI writes back the sign-extended offset
        fetch(32'h0000000D);
        tick(); #1;
        tick(); #1;
        chk("li_wb", 32'(bus.state_o), 32'd5);
        chk("li_wsel", 32'(bus.rf_wsel_o), 32'd2);
        tick(); #1;
        chk("li_instret", bus.instret_o, 32'd8);

        // DIV with result on the 10th DIV_WAIT cycle
        fetch(32'h000254B5);
        tick(); #1;
        chk("div_exec_start", 32'(bus.div_start_o), 32'd1);
        chk("div_exec_alu", 32'(bus.alu_op_o), 32'd5);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.div_done_i = (i == 9);
            #1;
            if (bus.div_start_o) pulses++;
            chk("div_wait_state", 32'(bus.state_o), 32'd3);
            chk("div_wait_alu", 32'(bus.alu_op_o), 32'd5);
        end
        chk("div_start_pulses", 32'(pulses), 32'd0);
        tick();
        bus.div_done_i = 1'b0;
        #1;
        chk("div_wb", 32'(bus.state_o), 32'd5);
        chk("div_rf_we", 32'(bus.rf_we_o), 32'd1);
        tick(); #1;
        chk("div_instret", bus.instret_o, 32'd9);

        // DIV timeout: 64 DIV_WAIT cycles, no retire
        fetch(32'h000254B5);
        tick(); tick(); #1;
        chk("to_enter", 32'(bus.state_o), 32'd3);
        chk("to_err_before", 32'(bus.div_err_o), 32'd0);
        n = 0;
        last_pc_en = 1'b0;
        while (bus.state_o == 3'd3 && n < 200) begin
            n++;
            last_pc_en = bus.pc_en_o;
            tick(); #1;
        end
        chk("to_cycles", 32'(n), 32'd64);
        chk("to_pc_en", 32'(last_pc_en), 32'd1);
        chk("to_state", 32'(bus.state_o), 32'd0);
        chk("to_err", 32'(bus.div_err_o), 32'd1);
        chk("to_instret", bus.instret_o, 32'd9);

        // Illegal opcode
        fetch(32'h0000000E);
        chk("ill_pulse", 32'(bus.illegal_o), 32'd1);
        chk("ill_pc_en", 32'(bus.pc_en_o), 32'd1);
        chk("ill_pc_sel", 32'(bus.pc_sel_o), 32'd0);
        tick(); #1;
        chk("ill_fetch", 32'(bus.state_o), 32'd0);
        chk("ill_pulse_end", 32'(bus.illegal_o), 32'd0);
        chk("ill_instret", bus.instret_o, 32'd9);

        // run_i=0 ignores a stray ack
        bus.run_i = 1'b0;
        bus.imem_ack_i = 1'b1;
        bus.instr_i = 32'h00004230;
        #1;
        chk("idle_req", 32'(bus.imem_req_o), 32'd0);
        chk("idle_ir_load", 32'(bus.ir_load_o), 32'd0);
        tick(); tick(); #1;
        chk("idle_state", 32'(bus.state_o), 32'd0);
        bus.imem_ack_i = 1'b0;
        bus.run_i = 1'b1;

        // Asynchronous reset in the middle of DIV_WAIT
        fetch(32'h000254B5);
        tick(); tick(); tick(); #1;
        chk("mid_div_state", 32'(bus.state_o), 32'd3);
        rst_i = 1'b1;
        #1;
        chk("arst_state", 32'(bus.state_o), 32'd0);
        chk("arst_outs", all_outs(), 32'd0);
        chk("arst_instret", bus.instret_o, 32'd0);
        tick();
        rst_i = 1'b0;
        #1;
        chk("arst_release_req", 32'(bus.imem_req_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
